// File: rtl/mmio_out_buffer.sv
// Memory-mapped output FIFO: stores to BASE_ADDR queue words for a downstream consumer,
// loads from BASE_ADDR+2 return status. Optional sticky overflow flag: MMIO_OUT_OVERFLOW_FLAG_EN.
module mmio_out_buffer #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter int          DEPTH     = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic        io_hit,
  output logic [15:0] io_rdata,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  count
);

  localparam int          DATA_W    = 16;
  localparam int          PTR_W     = $clog2(DEPTH);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd2;
  localparam logic [3:0]  DEPTH_C   = 4'(DEPTH);

  if (DEPTH != 2 && DEPTH != 4 && DEPTH != 8) begin : g_bad_depth
    $error("mmio_out_buffer: DEPTH must be 2, 4 or 8");
  end

  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              data_sel;
  logic              stat_sel;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              ovf;

  function automatic logic [15:0] status_word(input logic [3:0] cnt, input logic f,
                                              input logic e, input logic o);
    return {o, 7'b0, cnt, 2'b00, f, e};
  endfunction

  assign data_sel  = (mem_addr == BASE_ADDR);
  assign stat_sel  = (mem_addr == STAT_ADDR);
  assign io_hit    = data_sel || stat_sel;
  assign empty     = (count == 4'd0);
  assign full      = (count == DEPTH_C);
  assign out_valid = !empty;
  assign out_data  = fifo_mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign push      = mem_write && data_sel && (!full || pop);

  always_ff @(posedge CLK) begin
    if (push && reset) begin
      fifo_mem[wr_ptr] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      count    <= 4'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      io_rdata <= 16'h0000;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      // Loads see the state as it was before this edge's push/pop.
      if (mem_read && stat_sel) begin
        io_rdata <= status_word(count, full, empty, ovf);
      end else if (mem_read && data_sel) begin
        io_rdata <= out_data;
      end
    end
  end

`ifdef MMIO_OUT_OVERFLOW_FLAG_EN
  logic drop;
  assign drop = mem_write && data_sel && full && !pop;

  // A drop in the same cycle as a clear request leaves the flag set.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (mem_write && stat_sel && mem_wdata[15]) begin
      ovf <= 1'b0;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_out_buffer.sv
// Bench for mmio_out_buffer: table of access vectors with hand-derived expectations,
// a queue scoreboard for FIFO ordering, and hand-written reset/overflow sequences.
module tb_mmio_out_buffer;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] STAT = 16'hFF02;
`ifdef MMIO_OUT_OVERFLOW_FLAG_EN
  localparam logic [15:0] FULL_DROP_STAT = 16'h8042;
  localparam logic        OVF_EN = 1'b1;
`else
  localparam logic [15:0] FULL_DROP_STAT = 16'h0042;
  localparam logic        OVF_EN = 1'b0;
`endif

  logic        CLK;
  logic        reset;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic        io_hit;
  logic [15:0] io_rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  count;

  mmio_out_buffer #(.BASE_ADDR(16'hFF00), .DEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .io_hit(io_hit), .io_rdata(io_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic        rd;
    logic        rdy;
    logic        exp_hit;
    logic [3:0]  exp_count;
    logic        chk_rd;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [0:22];
  logic [15:0] sb [$];
  logic        m_ovf;
  logic [15:0] m_rdata;
  logic        m_known;
  int          n_cmp;
  int          n_fail;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] d, input logic w,
                              input logic r, input logic rdy, input logic hit,
                              input logic [3:0] c, input logic cr, input logic [15:0] er);
    vec_t v;
    v.addr = a; v.wdata = d; v.wr = w; v.rd = r; v.rdy = rdy;
    v.exp_hit = hit; v.exp_count = c; v.chk_rd = cr; v.exp_rdata = er;
    return v;
  endfunction

  // Drives one cycle (inputs set 1 time unit after a rising edge), checks the
  // pre-edge FIFO view against the scoreboard, then advances the model.
  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic w,
                      input logic r, input logic rdy, input logic rst_n);
    int          sz;
    logic        m_pop, m_push, m_drop, m_full;
    logic [15:0] m_stat;
    mem_addr = a; mem_wdata = d; mem_write = w; mem_read = r;
    out_ready = rdy; reset = rst_n;
    #1;
    sz = sb.size();
    if (m_known) begin
      chk("count_pre", {12'h0, count}, 16'(sz));
      chk("out_valid_pre", {15'h0, out_valid}, {15'h0, (sz != 0)});
      if (sz != 0) chk("out_data_head", out_data, sb[0]);
    end
    m_full = (sz == 4);
    m_pop  = rdy && (sz != 0);
    m_push = w && (a == BASE) && (!m_full || m_pop);
    m_drop = w && (a == BASE) && m_full && !m_pop;
    m_stat = {m_ovf, 7'b0, 4'(sz), 2'b00, m_full, (sz == 0)};
    @(posedge CLK);
    #1;
    if (!rst_n) begin
      sb.delete();
      m_ovf   = 1'b0;
      m_rdata = 16'h0000;
      m_known = 1'b1;
    end else begin
      if (r && a == STAT) m_rdata = m_stat;
      else if (r && a == BASE && sz != 0) m_rdata = sb[0];
      if (m_pop) void'(sb.pop_front());
      if (m_push) sb.push_back(d);
      if (OVF_EN) begin
        if (m_drop) m_ovf = 1'b1;
        else if (w && a == STAT && d[15]) m_ovf = 1'b0;
      end
    end
    if (m_known) chk("io_rdata_model", io_rdata, m_rdata);
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; m_known = 1'b0; m_ovf = 1'b0; m_rdata = 16'h0;
    reset = 1'b0; mem_addr = 16'h0; mem_wdata = 16'h0;
    mem_write = 1'b0; mem_read = 1'b0; out_ready = 1'b0;

    vecs[0]  = mk(BASE, 16'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000);
    vecs[1]  = mk(BASE, 16'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0000);
    vecs[2]  = mk(STAT, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 16'h0020);
    vecs[3]  = mk(BASE, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 16'h1111);
    vecs[4]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0000);
    vecs[5]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
    vecs[6]  = mk(STAT, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 16'h0001);
    vecs[7]  = mk(BASE, 16'hA000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 16'h0000);
    vecs[8]  = mk(BASE, 16'hA001, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 16'h0000);
    vecs[9]  = mk(BASE, 16'hA002, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 16'h0000);
    vecs[10] = mk(BASE, 16'hA003, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 16'h0000);
    vecs[11] = mk(BASE, 16'hA004, 1'b1, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0, 16'h0000);
    vecs[12] = mk(STAT, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b1, FULL_DROP_STAT);
    vecs[13] = mk(BASE, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 16'h0000);
    vecs[14] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 16'h0000);
    vecs[15] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 16'h0000);
    vecs[16] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0000);
    vecs[17] = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0000);
    vecs[18] = mk(STAT, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 16'h0000);
    vecs[19] = mk(STAT, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 16'h0001);
    vecs[20] = mk(16'hFF04, 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 16'h0000);
    vecs[21] = mk(16'hFF04, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 16'h0001);
    vecs[22] = mk(STAT, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1, 16'h0001);

    // Two reset edges, then the reset state.
    step(16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(BASE, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_count", {12'h0, count}, 16'h0000);
    chk("rst_out_valid", {15'h0, out_valid}, 16'h0000);
    chk("rst_io_rdata", io_rdata, 16'h0000);

    for (int i = 0; i <= 22; i++) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].wr, vecs[i].rd, vecs[i].rdy, 1'b1);
      chk($sformatf("vec%0d_io_hit", i), {15'h0, io_hit}, {15'h0, vecs[i].exp_hit});
      chk($sformatf("vec%0d_count", i), {12'h0, count}, {12'h0, vecs[i].exp_count});
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_io_rdata", i), io_rdata, vecs[i].exp_rdata);
    end

    // Fall-through: a single push into an empty FIFO is visible right after the edge.
    step(BASE, 16'hC0DE, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("fwft_valid", {15'h0, out_valid}, 16'h0001);
    chk("fwft_data", out_data, 16'hC0DE);

    // Fill, overflow, drain one to count=3, then a one-edge reset with a store that is lost.
    for (int i = 0; i < 4; i++) step(BASE, 16'hD000 + 16'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    chk("full_count", {12'h0, count}, 16'h0004);
    step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("mid_count", {12'h0, count}, 16'h0003);
    step(BASE, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("midrst_count", {12'h0, count}, 16'h0000);
    chk("midrst_valid", {15'h0, out_valid}, 16'h0000);
    step(STAT, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("midrst_status", io_rdata, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_out_buffer.md
MMIO_OUT_BUFFER -- requirements
Module: mmio_out_buffer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 16'hFF00: data-port address; the status port is BASE_ADDR+2.
REQ-002 The block SHALL have parameter DEPTH, default 4: FIFO entries; legal values are 2, 4 and 8 only.
REQ-003 The block SHALL have port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-low reset; reset=0 at a rising CLK edge resets the block.
REQ-005 The block SHALL have port mem_addr, input, 16: the datapath memory address.
REQ-006 The block SHALL have port mem_wdata, input, 16: the datapath store data.
REQ-007 The block SHALL have port mem_write, input, 1: the datapath store strobe, one cycle per store.
REQ-008 The block SHALL have port mem_read, input, 1: the datapath load strobe, one cycle per load.
REQ-009 The block SHALL have port io_hit, output, 1: combinational; high when mem_addr is BASE_ADDR or BASE_ADDR+2, so the datapath suppresses its RAM access.
REQ-010 The block SHALL have port io_rdata, output, 16: registered load data.
REQ-011 The block SHALL have port out_data, output, 16: the FIFO head word.
REQ-012 The block SHALL have port out_valid, output, 1: high when the FIFO is non-empty.
REQ-013 The block SHALL have port out_ready, input, 1: the downstream consumer accepts out_data.
REQ-014 The block SHALL have port count, output, 4: the current FIFO occupancy, 0..DEPTH.

Function
REQ-015 A push SHALL occur when mem_write=1, mem_addr=BASE_ADDR and count<DEPTH; mem_wdata is written at the tail.
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1; the head advances.
REQ-017 The FIFO SHALL be first-word fall-through: a push at edge N makes out_valid=1 and out_data equal to that word immediately after edge N when the FIFO was empty.
REQ-018 A push and a pop in the same cycle SHALL both take effect; count is unchanged, including when count=DEPTH.
REQ-019 A store to BASE_ADDR with count=DEPTH and no simultaneous pop SHALL be dropped; FIFO contents and pointers are unchanged.
REQ-020 Read and write pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and count SHALL never exceed DEPTH or fall below 0.
REQ-021 A load with mem_read=1 and mem_addr=BASE_ADDR+2 SHALL update io_rdata at the next edge to the status word, sampled before that edge's push/pop:
- bit0 = empty
- bit1 = full
- bits7:4 = count
- bit15 = overflow
- all other bits 0
REQ-022 A load with mem_read=1 and mem_addr=BASE_ADDR SHALL return out_data in io_rdata at the next edge and SHALL NOT pop the FIFO.
REQ-023 io_rdata SHALL hold its value when no I/O load occurs.
REQ-024 Stores to BASE_ADDR+2 SHALL NOT push; they are used only as described in REQ-029.
REQ-025 Accesses to any other address SHALL leave all state unchanged.

Reset
REQ-026 With reset=0 at a rising edge, the block SHALL set count=0, pointers=0, out_valid=0, io_rdata=16'h0000 and overflow=0; storage contents need not be cleared.
REQ-027 Reset SHALL take priority over any simultaneous push, pop or load; a store coinciding with reset is lost.

Configuration
REQ-028 With macro MMIO_OUT_OVERFLOW_FLAG_EN defined, a dropped store (REQ-019) SHALL set a sticky overflow bit.
REQ-029 With MMIO_OUT_OVERFLOW_FLAG_EN defined, a store to BASE_ADDR+2 with mem_wdata[15]=1 SHALL clear the overflow bit; a simultaneous drop SHALL win and leave the bit set.
REQ-030 With MMIO_OUT_OVERFLOW_FLAG_EN undefined, no overflow register SHALL exist, status bit15 SHALL read 0, and stores to BASE_ADDR+2 SHALL have no effect.

Verification
REQ-031 Reset then FIFO fill: hold reset=0 for 2 edges, then store 16'h1111, 16'h2222 to 16'hFF00 with out_ready=0 -> count=2, out_valid=1, out_data=16'h1111.
REQ-032 Drain ordering: with out_ready=1 after REQ-031 -> out_data 16'h1111 then 16'h2222 on consecutive cycles, then out_valid=0, count=0.
REQ-033 Full and drop: store 5 words A0..A4 with out_ready=0 at DEPTH=4 -> count=4, status load gives 16'h8042 (16'h0042 without the macro), and the drained order is A0..A3.
REQ-034 Simultaneous push and pop when full: store 16'hBEEF with out_ready=1 while count=4 -> count stays 4, and 16'hBEEF is drained last.
REQ-035 Mid-operation reset: with count=3, drive reset=0 for one edge -> next cycle count=0, out_valid=0 and status load reads 16'h0001.
REQ-036 Overflow clear and address decode: store 16'h8000 to 16'hFF02 -> bit15 clears; a store to 16'hFF04 -> io_hit=0 and state unchanged.
